// File: rtl/pll_lock_sequencer.sv
// PLL/DCM reset supervisor: holds the PLL in reset, qualifies a synchronized LOCKED, then releases DCM and fabric resets.
// lk lags pll_locked_i by 2 cycles and outputs are registered off next state; no backpressure. Option: PLL_LOCK_LOSS_COUNT_EN.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned DCM_CYCLES    = 256,
    parameter int unsigned CNT_W         = 20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pll_locked_i,
    input  logic        force_relock_i,
    output logic        pll_rst_o,
    output logic        dcm_rst_o,
    output logic        sys_rst_o,
    output logic        ready_o,
    output logic [2:0]  state_o,
    output logic [7:0]  retries_o
`ifdef PLL_LOCK_LOSS_COUNT_EN
    ,
    output logic [15:0] lock_loss_count_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_DCM_WAIT  = 3'd4,
        ST_RUN       = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCM_LAST    = CNT_W'(DCM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retries_q, retries_d;
    logic             sync_meta_q, lk_q;
    logic             pll_rst_q, pll_rst_d;
    logic             dcm_rst_q, dcm_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             force_hit;

    // Two-flop synchronizer; lk_q is the only view of LOCKED the FSM uses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_meta_q <= 1'b0;
            lk_q        <= 1'b0;
        end else begin
            sync_meta_q <= pll_locked_i;
            lk_q        <= sync_meta_q;
        end
    end

    assign force_hit = force_relock_i &&
                       (state_q inside {ST_PLL_RST, ST_WAIT_LOCK, ST_STABLE, ST_DCM_WAIT, ST_RUN});

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (lk_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_PLL_RST;
                    cnt_d     = '0;
                    retries_d = (retries_q == 8'hFF) ? retries_q : retries_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STABLE: begin
                // A dropout here is treated as a slow lock, not a failed attempt.
                if (!lk_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_DCM_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DCM_WAIT: begin
                if (!lk_q) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end else if (cnt_q == DCM_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!lk_q) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (force_hit) begin
            state_d   = ST_PLL_RST;
            cnt_d     = '0;
            retries_d = retries_q;
        end
    end

    // Reset-tree outputs are decoded from the next state so they change on the same edge as state_q.
    always_comb begin
        pll_rst_d = 1'b1;
        dcm_rst_d = 1'b1;
        sys_rst_d = 1'b1;
        ready_d   = 1'b0;
        case (state_d)
            ST_WAIT_LOCK, ST_STABLE: begin
                pll_rst_d = 1'b0;
            end
            ST_DCM_WAIT: begin
                pll_rst_d = 1'b0;
                dcm_rst_d = 1'b0;
            end
            ST_RUN: begin
                pll_rst_d = 1'b0;
                dcm_rst_d = 1'b0;
                sys_rst_d = 1'b0;
                ready_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            retries_q <= '0;
            pll_rst_q <= 1'b1;
            dcm_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            pll_rst_q <= pll_rst_d;
            dcm_rst_q <= dcm_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
        end
    end

    assign pll_rst_o = pll_rst_q;
    assign dcm_rst_o = dcm_rst_q;
    assign sys_rst_o = sys_rst_q;
    assign ready_o   = ready_q;
    assign state_o   = state_q;
    assign retries_o = retries_q;

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [15:0] loss_cnt_q, loss_cnt_d;
    logic        run_loss;

    // A relock request on the same edge as the dropout is not counted as a loss.
    assign run_loss   = (state_q == ST_RUN) && !lk_q && !force_hit;
    assign loss_cnt_d = (run_loss && (loss_cnt_q != 16'hFFFF)) ? loss_cnt_q + 16'd1 : loss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_count_o = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: expected state timelines are built arithmetically from the stated durations.
module tb_pll_lock_sequencer;

    localparam int RC = 16;
    localparam int LT = 100;
    localparam int SC = 1024;
    localparam int DC = 256;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        pll_locked_i = 1'b0;
    logic        force_relock_i = 1'b0;
    logic        pll_rst_o, dcm_rst_o, sys_rst_o, ready_o;
    logic [2:0]  state_o;
    logic [7:0]  retries_o;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [15:0] lock_loss_count_o;
`endif

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int seg_t[$];
    int seg_s[$];

    always #5 clk_i = ~clk_i;

    pll_lock_sequencer #(
        .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .DCM_CYCLES(DC), .CNT_W(20)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .pll_locked_i(pll_locked_i),
        .force_relock_i(force_relock_i),
        .pll_rst_o(pll_rst_o),
        .dcm_rst_o(dcm_rst_o),
        .sys_rst_o(sys_rst_o),
        .ready_o(ready_o),
        .state_o(state_o),
        .retries_o(retries_o)
`ifdef PLL_LOCK_LOSS_COUNT_EN
        ,
        .lock_loss_count_o(lock_loss_count_o)
`endif
    );

    // Expected state after edge t: the last segment starting at or before t.
    function automatic int exp_state(input int t);
        int s;
        s = 0;
        foreach (seg_t[i]) if (seg_t[i] <= t) s = seg_s[i];
        return s;
    endfunction

    // {state, pll_rst, dcm_rst, sys_rst, ready} implied by a state.
    function automatic logic [6:0] exp_vec(input int st);
        logic [2:0] s3;
        s3 = st[2:0];
        return {s3, 1'(st <= 1), 1'(st <= 3), 1'(st != 5), 1'(st == 5)};
    endfunction

    function automatic logic [6:0] obs_vec();
        return {state_o, pll_rst_o, dcm_rst_o, sys_rst_o, ready_o};
    endfunction

    task automatic step();
        @(posedge clk_i);
        cyc++;
        #1;
    endtask

    task automatic do_reset(input logic lock_hi, output int r);
        rst_i = 1'b1;
        force_relock_i = 1'b0;
        pll_locked_i = lock_hi;
        repeat (3) step();
        rst_i = 1'b0;
        r = cyc;
    endtask

    task automatic test_reset();
        int r;
        do_reset(1'b0, r);
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        checks++; if (pll_rst_o !== 1'b1) begin errors++; $display("FAIL reset_pll_rst got=%b exp=1", pll_rst_o); end
        checks++; if (dcm_rst_o !== 1'b1) begin errors++; $display("FAIL reset_dcm_rst got=%b exp=1", dcm_rst_o); end
        checks++; if (sys_rst_o !== 1'b1) begin errors++; $display("FAIL reset_sys_rst got=%b exp=1", sys_rst_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        checks++; if (retries_o !== 8'd0) begin errors++; $display("FAIL reset_retries got=%0d exp=0", retries_o); end
`ifdef PLL_LOCK_LOSS_COUNT_EN
        checks++; if (lock_loss_count_o !== 16'd0) begin errors++; $display("FAIL reset_loss_count got=%0d exp=0", lock_loss_count_o); end
`endif
    endtask

    // Lock arrives L cycles after reset release (L=0: tied high throughout).
    task automatic test_power_up(input int L);
        int r, w, s;
        do_reset(L == 0, r);
        w = r + RC + 1;
        s = w + 1;
        if (L != 0 && r + L + 3 > s) s = r + L + 3;
        seg_t = {r, r + 1, w, s, s + SC, s + SC + DC};
        seg_s = {0, 1, 2, 3, 4, 5};
        while (cyc < s + SC + DC + 5) begin
            step();
            if (L != 0 && cyc == r + L) pll_locked_i = 1'b1;
            checks++;
            if (obs_vec() !== exp_vec(exp_state(cyc))) begin
                errors++; $display("FAIL power_up L=%0d cyc=%0d got=%b exp=%b", L, cyc - r, obs_vec(), exp_vec(exp_state(cyc)));
            end
        end
        checks++; if (retries_o !== 8'd0) begin errors++; $display("FAIL power_up_retries got=%0d exp=0", retries_o); end
    endtask

    task automatic test_timeout();
        int r, u, est, eret;
        do_reset(1'b0, r);
        while (cyc < r + 1 + (RC + LT) * 257 + 10) begin
            step();
            u = cyc - r - 1;
            est = (u % (RC + LT) < RC) ? 1 : 2;
            eret = u / (RC + LT);
            if (eret > 255) eret = 255;
            checks++;
            if (obs_vec() !== exp_vec(est)) begin
                errors++; $display("FAIL timeout_state cyc=%0d got=%b exp=%b", u, obs_vec(), exp_vec(est));
            end
            checks++;
            if (retries_o !== 8'(eret)) begin
                errors++; $display("FAIL timeout_retries cyc=%0d got=%0d exp=%0d", u, retries_o, eret);
            end
        end
    endtask

    // One-cycle dropout of lk seen G cycles into STABLE.
    task automatic test_stable_glitch(input int G);
        int r, s, e;
        do_reset(1'b1, r);
        s = r + RC + 2;
        e = s + G - 3;
        seg_t = {r, r + 1, r + RC + 1, s, s + G, s + G + 1, s + G + 1 + SC, s + G + 1 + SC + DC};
        seg_s = {0, 1, 2, 3, 2, 3, 4, 5};
        while (cyc < s + G + 1 + SC + DC + 3) begin
            step();
            if (cyc == e) pll_locked_i = 1'b0;
            if (cyc == e + 1) pll_locked_i = 1'b1;
            checks++;
            if (obs_vec() !== exp_vec(exp_state(cyc))) begin
                errors++; $display("FAIL stable_glitch G=%0d cyc=%0d got=%b exp=%b", G, cyc - r, obs_vec(), exp_vec(exp_state(cyc)));
            end
        end
        checks++; if (retries_o !== 8'd0) begin errors++; $display("FAIL glitch_retries got=%0d exp=0", retries_o); end
    endtask

    task automatic test_run_loss();
        int start, e, x;
        checks++; if (state_o !== 3'd5) begin errors++; $display("FAIL run_loss_pre got=%0d exp=5", state_o); end
        start = cyc;
        e = start + int'($urandom_range(1, 50));
        x = int'($urandom_range(3, 10));
        seg_t = {start, e + 3, e + 3 + RC, e + 4 + RC, e + 4 + RC + SC, e + 4 + RC + SC + DC};
        seg_s = {5, 1, 2, 3, 4, 5};
        while (cyc < e + 4 + RC + SC + DC + 3) begin
            step();
            if (cyc == e) pll_locked_i = 1'b0;
            if (cyc == e + x) pll_locked_i = 1'b1;
            checks++;
            if (obs_vec() !== exp_vec(exp_state(cyc))) begin
                errors++; $display("FAIL run_loss cyc=%0d got=%b exp=%b", cyc - e, obs_vec(), exp_vec(exp_state(cyc)));
            end
        end
        checks++; if (retries_o !== 8'd0) begin errors++; $display("FAIL run_loss_retries got=%0d exp=0", retries_o); end
`ifdef PLL_LOCK_LOSS_COUNT_EN
        checks++; if (lock_loss_count_o !== 16'd1) begin errors++; $display("FAIL run_loss_count got=%0d exp=1", lock_loss_count_o); end
`endif
    endtask

    // Relock request on the same edge lk is first seen low, then a second request mid PLL_RST.
    task automatic test_force_relock();
        int start, f, j;
        start = cyc;
        f = start + int'($urandom_range(4, 40));
        j = int'($urandom_range(2, 14));
        seg_t = {start, f, f + j + RC, f + j + RC + 1, f + j + RC + 1 + SC, f + j + RC + 1 + SC + DC};
        seg_s = {5, 1, 2, 3, 4, 5};
        while (cyc < f + j + RC + 1 + SC + DC + 3) begin
            step();
            if (cyc == f - 3) pll_locked_i = 1'b0;
            if (cyc == f - 1 || cyc == f + j - 1) force_relock_i = 1'b1;
            if (cyc == f || cyc == f + j) force_relock_i = 1'b0;
            if (cyc == f) pll_locked_i = 1'b1;
            checks++;
            if (obs_vec() !== exp_vec(exp_state(cyc))) begin
                errors++; $display("FAIL force_relock j=%0d cyc=%0d got=%b exp=%b", j, cyc - f, obs_vec(), exp_vec(exp_state(cyc)));
            end
        end
        checks++; if (retries_o !== 8'd0) begin errors++; $display("FAIL force_retries got=%0d exp=0", retries_o); end
`ifdef PLL_LOCK_LOSS_COUNT_EN
        checks++; if (lock_loss_count_o !== 16'd1) begin errors++; $display("FAIL force_loss_count got=%0d exp=1", lock_loss_count_o); end
`endif
    endtask

    // One timeout, lock, then rst lands somewhere inside DCM_WAIT and the sequence restarts.
    task automatic test_rst_mid_dcm();
        int r, x, eret;
        do_reset(1'b0, r);
        x = int'($urandom_range(r + 1159, r + 1400));
        seg_t = {r, r + 1, r + 17, r + 117, r + 133, r + 134, r + 1158,
                 x, x + 1, x + RC + 1, x + RC + 2, x + RC + 2 + SC, x + RC + 2 + SC + DC};
        seg_s = {0, 1, 2, 1, 2, 3, 4, 0, 1, 2, 3, 4, 5};
        while (cyc < x + RC + 2 + SC + DC + 3) begin
            step();
            if (cyc == r + 120) pll_locked_i = 1'b1;
            if (cyc == x - 1) rst_i = 1'b1;
            if (cyc == x) rst_i = 1'b0;
            eret = (cyc >= r + 117 && cyc < x) ? 1 : 0;
            checks++;
            if (obs_vec() !== exp_vec(exp_state(cyc))) begin
                errors++; $display("FAIL rst_mid_dcm cyc=%0d got=%b exp=%b", cyc - r, obs_vec(), exp_vec(exp_state(cyc)));
            end
            checks++;
            if (retries_o !== 8'(eret)) begin
                errors++; $display("FAIL rst_mid_dcm_retries cyc=%0d got=%0d exp=%0d", cyc - r, retries_o, eret);
            end
        end
`ifdef PLL_LOCK_LOSS_COUNT_EN
        checks++; if (lock_loss_count_o !== 16'd0) begin errors++; $display("FAIL rst_loss_count got=%0d exp=0", lock_loss_count_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_power_up(0);
        test_power_up(int'($urandom_range(1, 90)));
        test_timeout();
        test_stable_glitch(500);
        test_run_loss();
        test_force_relock();
        test_stable_glitch(int'($urandom_range(1, 1023)));
        test_rst_mid_dcm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Supervisor for a PLL/DCM clock tree: drives the PLL reset input, watches the asynchronous LOCKED return, and sequences downstream DCM and system resets.
- Runs on a free-running oscillator clock that does not depend on the PLL.
- Handles lock timeout with retry, detects lock loss and supports software-forced relock.
- Sits beside the board clock generator; its outputs feed the PLL RST, the DCM RST and the fabric reset tree.

Parameters:
- RST_CYCLES, 16: pll_rst assertion width in clk cycles, minimum 1.
- LOCK_TIMEOUT, 65536: cycles to wait for lock before a retry.
- STABLE_CYCLES, 1024: cycles the synchronized lock must stay continuously high before it is accepted.
- DCM_CYCLES, 256: cycles dcm_rst is held low-to-ready before sys_rst releases.
- CNT_W, 20: width of the shared cycle counter; must hold the largest of the above.

Ports:
- clk, in, 1: free-running oscillator clock.
- rst, in, 1: synchronous active-high reset.
- pll_locked, in, 1: PLL LOCKED; asynchronous to clk.
- force_relock, in, 1: one-cycle request to restart the sequence.
- pll_rst, out, 1: PLL reset, active high.
- dcm_rst, out, 1: downstream DCM reset, active high.
- sys_rst, out, 1: fabric reset, active high.
- ready, out, 1: high only in RUN.
- state, out, 3: current FSM state encoding.
- retries, out, 8: saturating count of lock timeouts.

Behaviour:
- Input sync: pll_locked passes through a 2-flop synchronizer to give lk. All decisions use lk, so there are 2 cycles of sync latency.
- Reset values, with rst high at a clock edge:
  - state = IDLE.
  - pll_rst = 1, dcm_rst = 1, sys_rst = 1, ready = 0.
  - retries = 0, counter = 0, synchronizer flops = 0.
- State encodings: IDLE=0, PLL_RST=1, WAIT_LOCK=2, STABLE=3, DCM_WAIT=4, RUN=5. Codes 6–7 are illegal and go to IDLE on the next cycle.
- IDLE: go to PLL_RST on the next cycle and clear the counter.
- PLL_RST:
  - pll_rst=1, dcm_rst=1, sys_rst=1.
  - Counter increments each cycle.
  - After exactly RST_CYCLES cycles in this state, go to WAIT_LOCK and clear the counter.
- WAIT_LOCK:
  - pll_rst=0; dcm_rst and sys_rst stay 1.
  - If lk=1, go to STABLE and clear the counter.
  - Otherwise, when the counter reaches LOCK_TIMEOUT-1: retries increments (saturates at 255), then go to PLL_RST.
- STABLE:
  - If lk drops, return to WAIT_LOCK with the counter cleared. This does not count as a retry, and the timeout restarts.
  - After STABLE_CYCLES consecutive cycles with lk=1, go to DCM_WAIT.
- DCM_WAIT:
  - dcm_rst=0; sys_rst stays 1.
  - After DCM_CYCLES cycles, go to RUN.
  - If lk drops, go to PLL_RST.
- RUN:
  - Outputs: sys_rst=0, ready=1, all resets low.
  - If lk drops: sys_rst, dcm_rst and pll_rst are registered high on the next edge, and the FSM enters PLL_RST. Lock-loss-to-sys_rst latency is 3 cycles from the raw input: 2 sync + 1 registered.
- force_relock:
  - Sampled in any state except IDLE; forces PLL_RST with the counter cleared.
  - Wins over every other transition on the same cycle.
  - Does not increment retries.
- Priority, highest first: rst, force_relock, lk loss, timer expiry.
- Outputs are registered and decoded from the next state, so no combinational glitches reach the reset tree.
- retries clears only on rst.

Optional Feature:
- Macro: PLL_LOCK_LOSS_COUNT_EN.
- When defined:
  - Adds output lock_loss_count[15:0].
  - Increments by 1 (saturating at 65535) on each RUN→PLL_RST transition caused by lk loss. force_relock does not count.
  - Reset value 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset release, pll_locked tied high (RST_CYCLES=16, STABLE_CYCLES=1024, DCM_CYCLES=256): pll_rst falls on cycle 17; dcm_rst falls after 1024 stable cycles; sys_rst and ready change after 256 more; state progresses 0→1→2→3→4→5.
- pll_locked held low, LOCK_TIMEOUT=100: state cycles PLL_RST→WAIT_LOCK every 116 cycles; retries reads 1, 2, 3 after each timeout; with the count forced near the top, retries saturates at 255.
- In STABLE, pll_locked glitches low for 1 cycle at stable count 500: FSM returns to WAIT_LOCK, retries unchanged, the stable count restarts, and ready is reached 1024+256 cycles after relock.
- In RUN, pll_locked drops: sys_rst=1 and ready=0 exactly 3 cycles later; pll_rst pulses for 16 cycles; with the macro defined, lock_loss_count becomes 1.
- force_relock pulse in RUN on the same cycle lk drops: enters PLL_RST once; retries unchanged; lock_loss_count (macro defined) unchanged.
- rst asserted mid-DCM_WAIT: next cycle state=0 and all resets=1; retries=0; the sequence then restarts normally.
